// File: rtl/mont_domain_conv.sv
// rtl/mont_domain_conv.sv - bit-serial normal <-> Montgomery domain converter
//
// Converts a K-bit operand into (dir=0: x*R mod M) or out of (dir=1: x*R^-1 mod M)
// the Montgomery domain, R = 2^K, using one modular doubling or halving per clock.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   start  conversion request, sampled in IDLE or FIN, ignored while busy
//   dir    0 = into Montgomery domain, 1 = out of Montgomery domain (sampled with start)
//   x      K-bit operand, any value 0..2^K-1 (sampled with start)
//   z      result register, holds the last completed conversion, always < M
//   busy   high while a conversion is running
//   done   one-cycle pulse, z valid from this cycle on
module mont_domain_conv #(
    parameter int             K = 8,
    parameter logic [K-1:0]   M = 8'd239
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         dir,
    input  logic [K-1:0] x,
    output logic [K-1:0] z,
    output logic         busy,
    output logic         done
);

    localparam int             CW   = $clog2(K) + 1;
    localparam logic [CW-1:0]  LAST = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    logic [K-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          dir_q;

    logic [K:0]    m_ext;
    logic [K:0]    dbl_t;
    logic [K:0]    dbl_r;
    logic [K:0]    hlv_t;
    logic [K-1:0]  step_next;
    logic [K-1:0]  load_val;

    // Step arithmetic is carried in K+1 bits: acc < M < 2^K, so 2*acc and
    // acc+M both fit without overflow, and one subtract keeps acc < M.
    always_comb begin
        m_ext     = {1'b0, M};
        dbl_t     = {acc, 1'b0};
        dbl_r     = (dbl_t >= m_ext) ? (dbl_t - m_ext) : dbl_t;
        // Adding the odd modulus to an odd acc makes the sum even, so the
        // shift is an exact division by two modulo M.
        hlv_t     = acc[0] ? ({1'b0, acc} + m_ext) : {1'b0, acc};
        step_next = dir_q ? K'(hlv_t >> 1) : K'(dbl_r);
        // M > 2^(K-1), so a single subtract fully reduces any K-bit input.
        load_val  = (x >= M) ? (x - M) : x;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
            z     <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    // FIN accepts a new request directly so conversions can
                    // run back-to-back without an idle cycle.
                    if (start) begin
                        acc   <= load_val;
                        dir_q <= dir;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= step_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        z     <= step_next;
                        state <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

endmodule

// File: tb/tb_mont_domain_conv.sv
// tb/tb_mont_domain_conv.sv - randomized and directed bench for mont_domain_conv
module tb_mont_domain_conv;

    localparam int           K   = 8;
    localparam int           M_I = 239;
    localparam logic [K-1:0] M   = 8'd239;

    logic         clk;
    logic         reset;
    logic         start;
    logic         dir;
    logic [K-1:0] x;
    logic [K-1:0] z;
    logic         busy;
    logic         done;

    int total;
    int bad;
    int rinv;

    mont_domain_conv #(.K(K), .M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .dir   (dir),
        .x     (x),
        .z     (z),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain modular arithmetic: x*2^K mod M or x*R^-1 mod M.
    function automatic int ref_conv(input logic d, input logic [K-1:0] v);
        int a;
        a = int'(v) % M_I;
        if (!d)
            return (a * (1 << K)) % M_I;
        else
            return (a * rinv) % M_I;
    endfunction

    // Transaction-level timing model: a request accepted when not busy
    // produces its result K clocks later with a one-cycle done.
    logic         m_busy;
    logic         m_done;
    logic [K-1:0] m_z;
    logic [K-1:0] m_pend;
    int           m_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_z    <= '0;
            m_pend <= '0;
            m_left <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_z    <= m_pend;
            end
            m_left <= m_left - 1;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= K'(ref_conv(dir, x));
                m_left <= K;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Issue a request at the current negedge and wait for done.
    task automatic conv(input logic d, input logic [K-1:0] v, input bit noise,
                        output int cyc, output int bc);
        start = 1'b1;
        dir   = d;
        x     = v;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        bc    = busy ? 1 : 0;
        while (!done && cyc < 4 * K) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                dir   = 1'($urandom_range(0, 1));
                x     = K'($urandom_range(0, 255));
            end
            @(negedge clk);
            cyc++;
            if (busy) bc++;
        end
        start = 1'b0;
        chk("done_seen", int'(done), 1);
    endtask

    int d_dir [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    int d_x   [9] = '{0, 238, 240, 255, 239, 17, 1, 27, 0};
    int d_z   [9] = '{0, 222, 17, 33, 0, 1, 225, 100, 0};

    initial begin
        int cyc;
        int bc;
        int e;
        int gap;
        logic         rd;
        logic [K-1:0] rx;
        bit           rn;

        total = 0;
        bad   = 0;
        start = 1'b0;
        dir   = 1'b0;
        x     = '0;
        reset = 1'b1;
        rinv  = 0;
        for (int r = 1; r < M_I; r++)
            if ((r * (1 << K)) % M_I == 1) rinv = r;

        fork
            forever begin
                @(negedge clk);
                chk("mon_busy", int'(busy), int'(m_busy));
                chk("mon_done", int'(done), int'(m_done));
                chk("mon_z",    int'(z),    int'(m_z));
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_z", int'(z), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        // Latency and pulse widths
        conv(1'b0, 8'd1, 1'b0, cyc, bc);
        chk("lat_cycles", cyc, K + 1);
        chk("lat_busy_cycles", bc, K);
        chk("lat_z", int'(z), 17);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);

        // Hand-computed boundary values
        for (int i = 0; i < 9; i++) begin
            conv(1'(d_dir[i]), K'(d_x[i]), 1'b0, cyc, bc);
            chk($sformatf("tbl_z[%0d]", i), int'(z), d_z[i]);
            @(negedge clk);
        end

        // Round trip with back-to-back start in FIN
        conv(1'b0, 8'd100, 1'b0, cyc, bc);
        chk("rt_fwd", int'(z), 27);
        conv(1'b1, 8'd27, 1'b0, cyc, bc);
        chk("rt_gap", cyc, K + 1);
        chk("rt_back", int'(z), 100);

        for (int v = 0; v < M_I; v++) begin
            e = ref_conv(1'b0, K'(v));
            conv(1'b0, K'(v), 1'b0, cyc, bc);
            chk("sweep_fwd", int'(z), e);
            conv(1'b1, K'(e), 1'b0, cyc, bc);
            chk("sweep_gap", cyc, K + 1);
            chk("sweep_back", int'(z), v);
        end
        @(negedge clk);

        // start noise during RUN is ignored; result then holds
        conv(1'b0, 8'd1, 1'b1, cyc, bc);
        chk("noise_lat", cyc, K + 1);
        chk("noise_z", int'(z), 17);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_z", int'(z), 17);
        end

        // Reset in the middle of a conversion
        start = 1'b1;
        dir   = 1'b0;
        x     = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_z", int'(z), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", int'(done), 0);
        end
        conv(1'b1, 8'd27, 1'b0, cyc, bc);
        chk("post_reset_lat", cyc, K + 1);
        chk("post_reset_z", int'(z), 100);
        @(negedge clk);

        // Randomized traffic with gaps and noise
        for (int i = 0; i < 300; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            rd = 1'($urandom_range(0, 1));
            rx = K'($urandom_range(0, 255));
            rn = 1'($urandom_range(0, 1));
            e  = ref_conv(rd, rx);
            conv(rd, rx, rn, cyc, bc);
            chk("rand_lat", cyc, K + 1);
            chk("rand_z", int'(z), e);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mont_domain_conv.md
Name: mont_domain_conv

Overview:
Sequential converter between the normal and Montgomery residue domains for modulus M, with R = 2^K. It is the entry/exit companion to the team's Montgomery multiplier. dir=0 maps an operand into the Montgomery domain: z = x*R mod M. dir=1 maps a result back out: z = x*R^-1 mod M. It uses bit-serial doubling or halving (one step per clock), with a start/busy/done handshake and a held result register.

Parameters:
K, 8, operand/result width in bits; R = 2^K.
M, 8'd239, odd modulus. Requires 2^(K-1) < M < 2^K, so one conditional subtract fully reduces any K-bit input.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  reset, asynchronous, active-high.
start  input  1  request conversion; sampled on rising clk edge.
dir  input  1  0 = into Montgomery (x*R mod M), 1 = out of Montgomery (x*R^-1 mod M); sampled with start.
x  input  K  operand, any value 0..2^K-1; sampled with start.
z  output  K  result register; holds last completed conversion.
busy  output  1  high while a conversion is in progress (state RUN).
done  output  1  one-cycle pulse; z valid from this cycle on.

Behaviour:
- Reset (async, any time incl. mid-conversion): state=IDLE, acc=0, cnt=0, dir_q=0, z=0, busy=0, done=0. An aborted conversion never produces done.
- Internal regs: acc [K-1:0], cnt (counts 0..K-1, width ceil(log2 K)+1), dir_q, state in {IDLE, RUN, FIN}.
- Load (start=1 sampled in IDLE or FIN):
  - acc <= (x >= M) ? x-M : x.
  - dir_q <= dir; cnt <= 0; state <= RUN.
- Step function, computed in K+1 bits so no overflow:
  - dir_q=0 (double): t = {acc,1'b0}; next = (t >= M) ? t-M : t.
  - dir_q=1 (halve): t = acc[0] ? acc+M : acc; next = t >> 1.
  - Invariant: acc < M after load and after every step.
- RUN, each clock:
  - acc <= next; cnt <= cnt+1.
  - When cnt == K-1: z <= next; state <= FIN.
  - start is ignored in RUN (no queueing, no restart).
- FIN: done=1 for exactly this cycle.
  - start=1 here: load as in IDLE; next state RUN, no idle gap.
  - Otherwise next state IDLE.
- Outputs: busy = (state==RUN) and done = (state==FIN), both decoded from registered state (glitch-free). z changes only on the RUN->FIN edge.
- Latency: start sampled at edge 0 -> K steps on edges 1..K -> done high in the cycle after edge K, i.e. K cycles after start is sampled. Throughput is one conversion per K+1 cycles (back-to-back via FIN).
- Results are always fully reduced: 0 <= z < M.
- Boundary cases:
  - x=0 gives z=0 in both directions.
  - x in [M, 2^K) is reduced at load.
  - x=M is treated as 0.
  - dir changes while busy have no effect.

Test Plan:
- K=8, M=239, R mod M = 17, R^-1 mod M = 225. dir=0, x=1 -> done exactly 8 cycles after start sampled, z=17; busy high for 8 cycles; done high 1 cycle.
- dir=0: x=0 -> z=0; x=238 -> z=222; x=240 -> z=17; x=255 -> z=33; x=239 -> z=0.
- dir=1: x=17 -> z=1; x=1 -> z=225; x=27 -> z=100.
- Round trip: dir=0 x=100 -> z=27, then start asserted in the FIN cycle with dir=1, x=27 -> z=100. The second done arrives 9 cycles after the first. Repeat for all x in 0..238 and check z==x.
- start pulsed during RUN with different x/dir -> ignored; the original result and done timing are unchanged. After done, z holds its value while start stays low for 20 cycles.
- reset asserted mid-RUN (cycle 4) -> z=0, busy=0, done=0 immediately. No done follows. A new start after reset release completes normally with the correct value.
